// File: rtl/pipe_csel_adder_if.sv
// -----------------------------------------------------------------------------
// pipe_csel_adder_if
//   Operand/result handshake bundle for the pipelined carry-select adder.
//
//   Input side  : i_valid / o_ready handshake carrying i_valA, i_valB,
//                 i_carry (add-mode carry-in) and i_sub (1 = A-B).
//   Output side : o_valid / i_ready handshake carrying o_sum and o_carry
//                 (o_carry in subtract mode means "no borrow").
//   o_overflow  : signed overflow flag, present only when CSEL_OVF_EN is
//                 defined.
//
//   Modports:
//     slave  - the adder itself (consumes operands, produces results)
//     master - whoever feeds operands and drains results
// -----------------------------------------------------------------------------
interface pipe_csel_adder_if #(
  parameter int AW = 16
);
  logic          i_valid;
  logic          o_ready;
  logic [AW-1:0] i_valA;
  logic [AW-1:0] i_valB;
  logic          i_carry;
  logic          i_sub;
  logic          o_valid;
  logic          i_ready;
  logic [AW-1:0] o_sum;
  logic          o_carry;
`ifdef CSEL_OVF_EN
  logic          o_overflow;
`endif

  modport slave (
    input  i_valid, i_valA, i_valB, i_carry, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_carry
`ifdef CSEL_OVF_EN
    , output o_overflow
`endif
  );

  modport master (
    output i_valid, i_valA, i_valB, i_carry, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_carry
`ifdef CSEL_OVF_EN
    , input o_overflow
`endif
  );
endinterface

// File: rtl/pipe_csel_adder.sv
// -----------------------------------------------------------------------------
// pipe_csel_adder
//   Pipelined carry-select adder/subtractor. The operand is cut into
//   NSEG = AW/SW segments; stage k resolves segment k by precomputing the
//   segment sum for carry-in 0 and 1 and picking one with the carry registered
//   by stage k-1 (stage 0 uses the operation carry-in). Latency is NSEG
//   cycles, throughput one operation per cycle, with full backpressure.
//
//   Parameters:
//     AW - operand/result width (multiple of SW)
//     SW - segment width; AW/SW is the pipeline depth (>= 1)
//
//   Ports:
//     i_clk   - clock, rising edge
//     i_rst_n - asynchronous active-low reset; flushes all in-flight data
//     bus     - pipe_csel_adder_if.slave (operand and result handshakes)
//
//   Optional feature (macro CSEL_OVF_EN):
//     adds bus.o_overflow, the registered signed two's-complement overflow of
//     the operation, aligned with o_sum.
// -----------------------------------------------------------------------------
module pipe_csel_adder #(
  parameter int AW = 16,
  parameter int SW = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pipe_csel_adder_if.slave       bus
);

  localparam int NSEG = AW / SW;

  // Per-stage registers. Each stage carries the full operand width; the
  // lower (already resolved) operand segments and the upper (not yet
  // resolved) sum segments are dead and get trimmed by synthesis.
  logic [AW-1:0]   aReg   [NSEG];
  logic [AW-1:0]   bReg   [NSEG];
  logic [AW-1:0]   sumReg [NSEG];
  logic [NSEG-1:0] carryReg;
  logic [NSEG-1:0] validReg;

  // Stage inputs (what each stage loads when the pipe advances)
  logic [AW-1:0]   inA    [NSEG];
  logic [AW-1:0]   inB    [NSEG];
  logic [AW-1:0]   inSum  [NSEG];
  logic [NSEG-1:0] inCarry;
  logic [NSEG-1:0] inValid;

  // Stage results after the carry select
  logic [AW-1:0]   nxtSum [NSEG];
  logic [NSEG-1:0] nxtCarry;

  logic            advEn;
  logic [AW-1:0]   bEff;
  logic            cinEff;

  // The whole pipe moves as one: it advances whenever the output register is
  // empty or being drained this cycle, which is also when input is accepted.
  assign advEn = !validReg[NSEG-1] || bus.i_ready;

  // Operand prep: subtract is A + ~B + 1, so i_carry is ignored in that mode.
  always_comb begin
    if (bus.i_sub) begin
      bEff   = ~bus.i_valB;
      cinEff = 1'b1;
    end else begin
      bEff   = bus.i_valB;
      cinEff = bus.i_carry;
    end
  end

  // Stage input routing: stage 0 takes the prepared operands, later stages
  // take the registers of the stage below.
  always_comb begin
    inA[0]     = bus.i_valA;
    inB[0]     = bEff;
    inSum[0]   = {AW{1'b0}};
    inCarry[0] = cinEff;
    inValid[0] = bus.i_valid;
    for (int k = 1; k < NSEG; k++) begin
      inA[k]     = aReg[k-1];
      inB[k]     = bReg[k-1];
      inSum[k]   = sumReg[k-1];
      inCarry[k] = carryReg[k-1];
      inValid[k] = validReg[k-1];
    end
  end

  // Carry-select per stage: both candidate sums are formed from the segment
  // operands only, the incoming carry just picks one.
  always_comb begin : stageSel
    logic [SW-1:0] segA;
    logic [SW-1:0] segB;
    logic [SW:0]   sum0;
    logic [SW:0]   sum1;
    logic [SW:0]   selSum;
    segA   = {SW{1'b0}};
    segB   = {SW{1'b0}};
    sum0   = {(SW+1){1'b0}};
    sum1   = {(SW+1){1'b0}};
    selSum = {(SW+1){1'b0}};
    for (int k = 0; k < NSEG; k++) begin
      segA = inA[k][k*SW +: SW];
      segB = inB[k][k*SW +: SW];
      sum0 = {1'b0, segA} + {1'b0, segB};
      sum1 = {1'b0, segA} + {1'b0, segB} + {{SW{1'b0}}, 1'b1};
      if (inCarry[k]) begin
        selSum = sum1;
      end else begin
        selSum = sum0;
      end
      nxtSum[k]               = inSum[k];
      nxtSum[k][k*SW +: SW]   = selSum[SW-1:0];
      nxtCarry[k]             = selSum[SW];
    end
  end

  // Pipeline registers: all stages load together on advance and hold
  // otherwise; bubbles travel as cleared valid bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        aReg[k]   <= {AW{1'b0}};
        bReg[k]   <= {AW{1'b0}};
        sumReg[k] <= {AW{1'b0}};
      end
      carryReg <= {NSEG{1'b0}};
      validReg <= {NSEG{1'b0}};
    end else if (advEn) begin
      for (int k = 0; k < NSEG; k++) begin
        aReg[k]   <= inA[k];
        bReg[k]   <= inB[k];
        sumReg[k] <= nxtSum[k];
      end
      carryReg <= nxtCarry;
      validReg <= inValid;
    end
  end

  assign bus.o_ready = advEn;
  assign bus.o_valid = validReg[NSEG-1];
  assign bus.o_sum   = sumReg[NSEG-1];
  assign bus.o_carry = carryReg[NSEG-1];

`ifdef CSEL_OVF_EN
  logic ovfNxt;
  logic ovfReg;

  // Carry into the MSB is recovered as a^b^s at that bit; overflow is that
  // carry disagreeing with the carry out of the MSB.
  always_comb begin
    ovfNxt = inA[NSEG-1][AW-1] ^ inB[NSEG-1][AW-1] ^ nxtSum[NSEG-1][AW-1]
           ^ nxtCarry[NSEG-1];
  end

  // Overflow flag travels with the last stage so it stays aligned with o_sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovfReg <= 1'b0;
    end else if (advEn) begin
      ovfReg <= ovfNxt;
    end
  end

  assign bus.o_overflow = ovfReg;
`endif

endmodule

// File: tb/tb_pipe_csel_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_csel_adder
//   Directed plus randomised checks of pipe_csel_adder (AW=16, SW=4).
//   Expected results are queued when an operand handshake happens and
//   compared when a result handshake happens. Inputs change on the falling
//   edge; outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_pipe_csel_adder;

  localparam int AW   = 16;
  localparam int SW   = 4;
  localparam int NSEG = AW / SW;

  typedef struct packed {
    logic [AW-1:0] sum;
    logic          carry;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;

  int   checks   = 0;
  int   failures = 0;

  exp_t expQ[$];
  exp_t pendExp;

  pipe_csel_adder_if #(.AW(AW)) busIf ();

  pipe_csel_adder #(.AW(AW), .SW(SW)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (busIf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Independent reference: full-width sum of A, effective B and carry-in.
  function automatic exp_t model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic c, input logic s);
    exp_t          r;
    logic [AW-1:0] be;
    logic          ci;
    logic [AW:0]   full;
    be      = s ? ~b : b;
    ci      = s ? 1'b1 : c;
    full    = {1'b0, a} + {1'b0, be} + {{AW{1'b0}}, ci};
    r.sum   = full[AW-1:0];
    r.carry = full[AW];
    r.ovf   = (a[AW-1] == be[AW-1]) && (full[AW-1] != a[AW-1]);
    return r;
  endfunction

  task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic c,
                       input logic s, input logic [AW-1:0] es, input logic ec, input logic eo);
    busIf.i_valid = 1'b1;
    busIf.i_valA  = a;
    busIf.i_valB  = b;
    busIf.i_carry = c;
    busIf.i_sub   = s;
    pendExp.sum   = es;
    pendExp.carry = ec;
    pendExp.ovf   = eo;
  endtask

  task automatic driveModel(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic c, input logic s);
    exp_t e;
    e = model(a, b, c, s);
    drive(a, b, c, s, e.sum, e.carry, e.ovf);
  endtask

  // Bubble with garbage operands: must never show up as a result.
  task automatic idle();
    busIf.i_valid = 1'b0;
    busIf.i_valA  = AW'($urandom);
    busIf.i_valB  = AW'($urandom);
    busIf.i_carry = 1'($urandom);
    busIf.i_sub   = 1'($urandom);
  endtask

  // One clock: evaluate both handshakes, update the scoreboard, advance to
  // the next falling edge. Returns whether the driven operand was accepted.
  task automatic cycle(output bit accepted);
    exp_t e;
    #1;
    accepted = busIf.i_valid && busIf.o_ready;
    if (busIf.o_valid && busIf.i_ready) begin
      if (expQ.size() == 0) begin
        check("result_without_op", {31'b0, busIf.o_valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("sum", {16'b0, busIf.o_sum}, {16'b0, e.sum});
        check("carry", {31'b0, busIf.o_carry}, {31'b0, e.carry});
`ifdef CSEL_OVF_EN
        check("overflow", {31'b0, busIf.o_overflow}, {31'b0, e.ovf});
`endif
      end
    end
    if (accepted) expQ.push_back(pendExp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    idle();
    busIf.i_ready = 1'b1;
    for (int t = 0; t < 60 && expQ.size() != 0; t++) cycle(acc);
    check("drain_left", expQ.size(), 32'd0);
  endtask

  // Single op on an empty pipe: count edges from accept to o_valid.
  task automatic latencyOp(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] es, input logic ec);
    bit acc;
    int n;
    busIf.i_ready = 1'b1;
    drive(a, b, 1'b0, 1'b0, es, ec, 1'b0);
    cycle(acc);
    check("latency_accept", {31'b0, acc}, 32'd1);
    idle();
    n = 1;
    while (!busIf.o_valid && n < 20) begin
      cycle(acc);
      n++;
    end
    check("latency", n, NSEG);
    drain();
  endtask

  initial begin
    bit acc;
    busIf.i_valid = 1'b0;
    busIf.i_valA  = '0;
    busIf.i_valB  = '0;
    busIf.i_carry = 1'b0;
    busIf.i_sub   = 1'b0;
    busIf.i_ready = 1'b1;
    pendExp       = '0;
    rstN          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_o_valid", {31'b0, busIf.o_valid}, 32'd0);
    check("rst_o_sum",   {16'b0, busIf.o_sum},   32'd0);
    check("rst_o_carry", {31'b0, busIf.o_carry}, 32'd0);
    check("rst_o_ready", {31'b0, busIf.o_ready}, 32'd1);
`ifdef CSEL_OVF_EN
    check("rst_o_overflow", {31'b0, busIf.o_overflow}, 32'd0);
`endif
    rstN = 1'b1;
    @(negedge clk);

    // Latency and carry ripple across a segment boundary
    latencyOp(16'h00FF, 16'h0001, 16'h0100, 1'b0);

    // Directed add/sub, back to back
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); cycle(acc);
    drive(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0); cycle(acc);
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); cycle(acc);
    drive(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0); cycle(acc);
    drain();

    // Stream 1+1..5+5 with a 3-cycle output stall after the first result
    busIf.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(AW'(i), AW'(i), 1'b0, 1'b0, AW'(2 * i), 1'b0, 1'b0);
      cycle(acc);
      check("stream_accept", {31'b0, acc}, 32'd1);
    end
    drive(16'h0005, 16'h0005, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_o_valid", {31'b0, busIf.o_valid}, 32'd1);
      check("stall_o_ready", {31'b0, busIf.o_ready}, 32'd0);
      check("stall_o_sum",   {16'b0, busIf.o_sum},   32'h0002);
      cycle(acc);
      check("stall_no_accept", {31'b0, acc}, 32'd0);
    end
    busIf.i_ready = 1'b1;
    cycle(acc);
    check("pop_push_accept", {31'b0, acc}, 32'd1);
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      driveModel(AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
      cycle(acc);
    end
    idle();
    rstN = 1'b0;
    #1;
    check("midrst_o_valid", {31'b0, busIf.o_valid}, 32'd0);
    check("midrst_o_sum",   {16'b0, busIf.o_sum},   32'd0);
    check("midrst_o_ready", {31'b0, busIf.o_ready}, 32'd1);
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < NSEG + 1; i++) begin
      #1;
      check("no_stale_result", {31'b0, busIf.o_valid}, 32'd0);
      cycle(acc);
    end
    latencyOp(16'h0003, 16'h0004, 16'h0007, 1'b0);

    // Random operands, bubbles and backpressure
    for (int i = 0; i < 40; i++) begin
      busIf.i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        idle();
        cycle(acc);
      end else begin
        driveModel(AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
          cycle(acc);
          busIf.i_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand_accept", {31'b0, acc}, 32'd1);
      end
    end
    drain();

`ifdef CSEL_OVF_EN
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); cycle(acc);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); cycle(acc);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0); cycle(acc);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
